code_length_checker: RTL

Parametrised, fully synchronous successor to the keypad length checker in the digital-lock datapath. Sits between the debounced keypad decoder and the code comparator/storage logic. Counts digits between delimiter keys for unlock entries and multi-phase reprogram entries. Reports whether each entry's length is legal, and for reprogramming, whether all phases agree in length.

---
 rtl/lock_pkg.sv | 24 ++
 rtl/code_length_checker_idle_timer.sv | 29 ++
 rtl/code_length_checker.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the digital-lock keypad datapath: default key codes,
// the length-checker state encoding and a digit classifier used by the
// decoder, comparator and length checker alike.
package lock_pkg;

  localparam int unsigned DEF_LOCK_KEY  = 9;
  localparam int unsigned DEF_PROG_KEY  = 8;
  localparam int unsigned DEF_CLEAR_KEY = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_LOCK = 2'd1,
    READ_PROG = 2'd2
  } lock_state_t;

  // A digit is any key that is not one of the three control keys.
  function automatic logic is_digit(input int unsigned key,
                                    input int unsigned lock_key,
                                    input int unsigned prog_key,
                                    input int unsigned clear_key);
    return (key != lock_key) && (key != prog_key) && (key != clear_key);
  endfunction

endpackage

// File: rtl/code_length_checker_idle_timer.sv
// idle_timer: free-running inactivity counter with synchronous clear and
// enable; raises expire combinationally while sitting on its terminal count.
module idle_timer #(
  parameter int unsigned W        = 24,
  parameter int unsigned TERMINAL = (1 << 24) - 1
) (
  input  logic hwclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [W-1:0] TC = W'(TERMINAL);

  logic [W-1:0] cnt_q;

  // Count idle cycles; parks on the terminal count until cleared.
  always_ff @(posedge hwclk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != TC)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire = enable && !clear && (cnt_q == TC);

endmodule

// File: rtl/code_length_checker.sv
// code_length_checker: counts digits between delimiter keys for unlock and
// multi-phase reprogram entries and reports length legality. Every output is
// a flop or a direct decode of the state register.
// Optional feature: define LEN_TIMEOUT_EN to add an idle timeout that returns
// the checker to IDLE after TIMEOUT_CYCLES cycles without a key.
module code_length_checker
  import lock_pkg::*;
#(
  parameter int unsigned BTN_W          = 4,
  parameter int unsigned MIN_LEN        = 4,
  parameter int unsigned MAX_LEN        = 6,
  parameter int unsigned NUM_PHASES     = 3,
  parameter int unsigned LOCK_KEY       = DEF_LOCK_KEY,
  parameter int unsigned PROG_KEY       = DEF_PROG_KEY,
  parameter int unsigned CLEAR_KEY      = DEF_CLEAR_KEY,
  parameter int unsigned TIMEOUT_CYCLES = 2 ** 24
) (
  input  logic                                hwclk,
  input  logic                                reset,
  input  logic                                key_valid,
  input  logic [BTN_W-1:0]                    button,
  input  logic                                input_wrong,
  output logic                                valid_uc,
  output logic                                valid_pc,
  output logic                                len_done,
  output logic                                mode,
  output logic [$clog2(NUM_PHASES+1)-1:0]     phase,
  output logic                                busy,
  output logic                                timeout
);

  localparam int unsigned CNT_W = $clog2(MAX_LEN + 2);
  localparam int unsigned PH_W  = $clog2(NUM_PHASES + 1);

  localparam logic [BTN_W-1:0] LOCK_CODE  = BTN_W'(LOCK_KEY);
  localparam logic [BTN_W-1:0] PROG_CODE  = BTN_W'(PROG_KEY);
  localparam logic [BTN_W-1:0] CLEAR_CODE = BTN_W'(CLEAR_KEY);

  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(MAX_LEN + 1);
  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(NUM_PHASES - 1);

  lock_state_t      state_q,    state_n;
  logic [CNT_W-1:0] count_q,    count_n;
  logic [CNT_W-1:0] ref_len_q,  ref_len_n;
  logic [PH_W-1:0]  phase_q,    phase_n;
  logic             prog_bad_q, prog_bad_n;
  logic             valid_uc_q, valid_uc_n;
  logic             valid_pc_q, valid_pc_n;
  logic             len_done_q, len_done_n;

  logic             expire;
  logic             do_clear;
  logic             digit;
  logic             in_range;
  logic             close_bad;
  logic [CNT_W-1:0] count_inc;

  assign digit     = is_digit(32'(button), LOCK_KEY, PROG_KEY, CLEAR_KEY);
  assign in_range  = (count_q >= MIN_C) && (count_q <= MAX_C);
  assign count_inc = (count_q == SAT_C) ? count_q : count_q + CNT_W'(1);
  // The closing phase's own checks fold into the verdict of this close.
  assign close_bad = prog_bad_q || !in_range ||
                     ((phase_q != '0) && (count_q != ref_len_q));

`ifdef LEN_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic timeout_q;

  idle_timer #(
    .W        (TMR_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_idle_timer (
    .hwclk  (hwclk),
    .reset  (reset),
    .clear  (key_valid || (state_q == IDLE)),
    .enable (state_q != IDLE),
    .expire (expire)
  );

  // Timeout pulse: only when the timer expires with no higher-priority event.
  always_ff @(posedge hwclk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire && !input_wrong && !key_valid;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // Next-state and next-output decode for the length-checker FSM.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_n    = state_q;
    count_n    = count_q;
    ref_len_n  = ref_len_q;
    phase_n    = phase_q;
    prog_bad_n = prog_bad_q;
    valid_uc_n = valid_uc_q;
    valid_pc_n = valid_pc_q;
    len_done_n = 1'b0;
    do_clear   = 1'b0;

    if (input_wrong) begin
      do_clear = 1'b1;
    end else if (key_valid) begin
      if (button == CLEAR_CODE) begin
        do_clear = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (button == LOCK_CODE) begin
              state_n    = READ_LOCK;
              count_n    = '0;
              valid_uc_n = 1'b0;
            end else if (button == PROG_CODE) begin
              state_n    = READ_PROG;
              count_n    = '0;
              phase_n    = '0;
              valid_pc_n = 1'b0;
              prog_bad_n = 1'b0;
            end
          end
          READ_LOCK: begin
            if (digit) begin
              count_n = count_inc;
            end else if (button == LOCK_CODE) begin
              state_n    = IDLE;
              count_n    = '0;
              valid_uc_n = in_range;
              len_done_n = 1'b1;
            end else begin
              state_n = IDLE;
              count_n = '0;
            end
          end
          READ_PROG: begin
            if (digit) begin
              count_n = count_inc;
            end else if (button == PROG_CODE) begin
              prog_bad_n = close_bad;
              count_n    = '0;
              if (phase_q == '0) begin
                ref_len_n = count_q;
              end
              if (phase_q == LAST_PH) begin
                state_n    = IDLE;
                phase_n    = '0;
                valid_pc_n = !close_bad;
                len_done_n = 1'b1;
              end else begin
                phase_n = phase_q + PH_W'(1);
              end
            end else begin
              state_n = IDLE;
              count_n = '0;
              phase_n = '0;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end else if (expire) begin
      do_clear = 1'b1;
    end

    if (do_clear) begin
      state_n    = IDLE;
      count_n    = '0;
      phase_n    = '0;
      valid_uc_n = 1'b0;
      valid_pc_n = 1'b0;
      prog_bad_n = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge hwclk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ref_len_q  <= '0;
      phase_q    <= '0;
      prog_bad_q <= 1'b0;
      valid_uc_q <= 1'b0;
      valid_pc_q <= 1'b0;
      len_done_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      ref_len_q  <= ref_len_n;
      phase_q    <= phase_n;
      prog_bad_q <= prog_bad_n;
      valid_uc_q <= valid_uc_n;
      valid_pc_q <= valid_pc_n;
      len_done_q <= len_done_n;
    end
  end

  assign valid_uc = valid_uc_q;
  assign valid_pc = valid_pc_q;
  assign len_done = len_done_q;
  assign phase    = phase_q;
  assign mode     = (state_q == READ_PROG);
  assign busy     = (state_q != IDLE);

endmodule
